// File: rtl/bufram_ctrl_if.sv
// ----------------------------------------------------------------------------
// bufram_ctrl_if : handshake/address bundle between a block-buffer controller
//                  and its stream source / buffer RAM.
// Purpose   : groups the stream qualifiers (ED, START) with the buffer
//             control outputs (WE, ODD, ADDRW, ADDRR, RDY, BUSY).
// Ports     : master = stream source / RAM side, drives ED and START.
//             slave  = bufram_ctrl, drives all buffer control outputs.
// ----------------------------------------------------------------------------
interface bufram_ctrl_if #(
   parameter int AW = 5
);
   logic          ED;      // clock enable / sample qualifier
   logic          START;   // marks sample 0 of a new stream
   logic          WE;      // buffer write enable
   logic          ODD;     // half select: write half ~ODD, read half ODD
   logic [AW-1:0] ADDRW;   // write address within current half
   logic [AW-1:0] ADDRR;   // read address within opposite half
   logic          RDY;     // read data for sample 0 of a block is valid
   logic          BUSY;    // controller is filling or running

   modport master (
      output ED, START,
      input  WE, ODD, ADDRW, ADDRR, RDY, BUSY
   );

   modport slave (
      input  ED, START,
      output WE, ODD, ADDRW, ADDRR, RDY, BUSY
   );
endinterface

// File: rtl/bufram_ctrl.sv
// ----------------------------------------------------------------------------
// bufram_ctrl : ping-pong (2x block) buffer RAM address/control generator.
// Ports   : CLK, RST (sync, active-high) plain; bus (bufram_ctrl_if.slave)
//           carries ED, START in and WE, ODD, ADDRW, ADDRR, RDY, BUSY out.
// Params  : AW  - block address width, block length N = 2**AW.
//           LAT - RAM read latency in ED-qualified cycles.
// Config  : BUFRAM_BITREV_READ_EN defined -> ADDRR is the bit-reversed read
//           index (FFT output order); undefined -> natural order.
// ----------------------------------------------------------------------------
// Purpose: writes block k into one RAM half while reading block k-1 from the other.
// Latency: WE/ODD/ADDRW/ADDRR/BUSY one cycle after the sample; RDY LAT ED cycles after ADDRR=0.
// Backpressure: none; ED low freezes every register and suppresses WE and RDY.
module bufram_ctrl #(
   parameter int AW  = 5,
   parameter int LAT = 1
) (
   input  logic        CLK,
   input  logic        RST,
   bufram_ctrl_if.slave bus
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_FILL = 2'd1,
      S_RUN  = 2'd2
   } state_t;

   // ------------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------------
   state_t          state_q, state_d;
   // Index the *next* ED-qualified sample will be written to. The write
   // index of the current sample is therefore wcnt_q itself, registered
   // into ADDRW; the read index in RUN is the same value.
   logic [AW-1:0]   wcnt_q,  wcnt_d;
   logic            we_q,    we_d;
   logic            odd_q,   odd_d;
   logic [AW-1:0]   addrw_q, addrw_d;
   logic [AW-1:0]   addrr_q, addrr_d;
   logic            busy_q,  busy_d;
   // Set while the registered ADDRR is the first read address of a block;
   // it is the entry point of the RDY delay line.
   logic            rd_first_q, rd_first_d;
   logic [LAT-1:0]  rdy_sr_q,   rdy_sr_d;

   // ------------------------------------------------------------------------
   // Read address ordering
   // ------------------------------------------------------------------------
   logic [AW-1:0]   rd_addr;

`ifdef BUFRAM_BITREV_READ_EN
   always_comb begin
      rd_addr = '0;
      for (int i = 0; i < AW; i++) begin
         rd_addr[i] = wcnt_q[AW-1-i];
      end
   end
`else
   always_comb begin
      rd_addr = wcnt_q;
   end
`endif

   // ------------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------------
   always_comb begin
      state_d    = state_q;
      wcnt_d     = wcnt_q;
      we_d       = 1'b0;          // WE only asserts on an ED-qualified write
      odd_d      = odd_q;
      addrw_d    = addrw_q;
      addrr_d    = addrr_q;
      rd_first_d = rd_first_q;
      rdy_sr_d   = rdy_sr_q;

      if (bus.ED) begin
         // RDY delay line advances only on ED-qualified cycles.
         rdy_sr_d[0] = rd_first_q;
         for (int i = 1; i < LAT; i++) begin
            rdy_sr_d[i] = rdy_sr_q[i-1];
         end
         rd_first_d = 1'b0;

         if (bus.START) begin
            // New stream (or restart): the START sample is sample 0 of a
            // fresh first block, so reads stop and pending RDYs are dropped.
            state_d  = S_FILL;
            wcnt_d   = AW'(1);
            we_d     = 1'b1;
            addrw_d  = '0;
            odd_d    = 1'b0;
            rdy_sr_d = '0;
         end else if (state_q != S_IDLE) begin
            we_d    = 1'b1;
            addrw_d = wcnt_q;
            wcnt_d  = wcnt_q + AW'(1);   // wraps modulo N

            // wcnt_q == 0 here means this sample opens a new block: swap
            // halves in step with ADDRW=0 and, on the first wrap, start
            // reading the block just completed.
            if (wcnt_q == '0) begin
               odd_d   = ~odd_q;
               state_d = S_RUN;
            end

            if ((state_q == S_RUN) || (wcnt_q == '0)) begin
               addrr_d    = rd_addr;
               rd_first_d = (wcnt_q == '0);
            end
         end
      end

      busy_d = (state_d != S_IDLE);
   end

   // ------------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------------
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q    <= S_IDLE;
         wcnt_q     <= '0;
         we_q       <= 1'b0;
         odd_q      <= 1'b0;
         addrw_q    <= '0;
         addrr_q    <= '0;
         busy_q     <= 1'b0;
         rd_first_q <= 1'b0;
         rdy_sr_q   <= '0;
      end else begin
         state_q    <= state_d;
         wcnt_q     <= wcnt_d;
         we_q       <= we_d;
         odd_q      <= odd_d;
         addrw_q    <= addrw_d;
         addrr_q    <= addrr_d;
         busy_q     <= busy_d;
         rd_first_q <= rd_first_d;
         rdy_sr_q   <= rdy_sr_d;
      end
   end

   // ------------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------------
   assign bus.WE    = we_q;
   assign bus.ODD   = odd_q;
   assign bus.ADDRW = addrw_q;
   assign bus.ADDRR = addrr_q;
   assign bus.BUSY  = busy_q;
   // The delay line holds while ED is low, so gating with ED yields exactly
   // one RDY cycle, always in an ED-qualified cycle.
   assign bus.RDY   = rdy_sr_q[LAT-1] & bus.ED;

endmodule

// File: tb/tb_bufram_ctrl.sv
// Bench for bufram_ctrl: directed stream scenarios followed by random ED /
// START / RST traffic, compared cycle by cycle against a stream-level model.
module tb_bufram_ctrl;

   localparam int AW  = 5;
   localparam int N   = 1 << AW;
   localparam int LAT = 2;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   bufram_ctrl_if #(.AW(AW)) bus ();

   bufram_ctrl #(.AW(AW), .LAT(LAT)) dut (
      .CLK (clk),
      .RST (rst),
      .bus (bus)
   );

   typedef struct packed {
      logic          we;
      logic          odd;
      logic [AW-1:0] addrw;
      logic [AW-1:0] addrr;
      logic          rdy;
      logic          busy;
   } exp_t;

   exp_t exp_q[$];
   int   checks   = 0;
   int   failures = 0;
   int   cyc      = 0;

   // ------------------------------------------------------------------------
   // Reference model: tracks the stream as "sample n since START" and derives
   // the buffer view from plain arithmetic on n.
   // ------------------------------------------------------------------------
   bit            m_active = 0;
   int            m_n      = 0;
   bit            m_we     = 0;
   bit            m_odd    = 0;
   logic [AW-1:0] m_addrw  = '0;
   logic [AW-1:0] m_addrr  = '0;
   int            m_pend[$];       // ED edges still to pass before RDY cycle

   function automatic logic [AW-1:0] read_order(input int idx);
      int v;
      logic [AW-1:0] r;
      v = idx % N;
      r = '0;
`ifdef BUFRAM_BITREV_READ_EN
      for (int b = 0; b < AW; b++) begin
         if (((v >> b) & 1) != 0) r[AW-1-b] = 1'b1;
      end
`else
      r = AW'(v);
`endif
      return r;
   endfunction

   function automatic bit rdy_due(input bit ed);
      bit hit;
      hit = 1'b0;
      foreach (m_pend[i]) if (m_pend[i] == 0) hit = 1'b1;
      return ed && hit;
   endfunction

   task automatic model_edge(input bit r, input bit e, input bit s);
      int keep[$];
      if (r) begin
         m_active = 0; m_n = 0; m_we = 0; m_odd = 0;
         m_addrw = '0; m_addrr = '0;
         m_pend.delete();
      end else if (e) begin
         keep.delete();
         foreach (m_pend[i]) if (m_pend[i] != 0) keep.push_back(m_pend[i] - 1);
         m_pend = keep;
         if (s) begin
            m_active = 1; m_n = 0; m_we = 1; m_odd = 0; m_addrw = '0;
            m_pend.delete();
         end else if (m_active) begin
            m_n++;
            m_we    = 1;
            m_addrw = AW'(m_n % N);
            m_odd   = ((m_n / N) % 2) != 0;
            if (m_n >= N) begin
               m_addrr = read_order(m_n);
               if ((m_n % N) == 0) m_pend.push_back(LAT);
            end
         end else begin
            m_we = 0;
         end
      end else begin
         m_we = 0;
      end
   endtask

   // One clock cycle: drive inputs, queue what the DUT must show during this
   // cycle, then advance the model across the closing edge.
   task automatic step(input bit r, input bit e, input bit s);
      exp_t x;
      #1;
      rst       = r;
      bus.ED    = e;
      bus.START = s;
      x.we    = m_we;
      x.odd   = m_odd;
      x.addrw = m_addrw;
      x.addrr = m_addrr;
      x.rdy   = rdy_due(e);
      x.busy  = m_active;
      exp_q.push_back(x);
      @(posedge clk);
      model_edge(r, e, s);
   endtask

   // ------------------------------------------------------------------------
   // Monitor: compares DUT outputs mid-cycle against the queued expectation.
   // ------------------------------------------------------------------------
   exp_t got, want;
   always @(negedge clk) begin
      cyc++;
      if (exp_q.size() > 0) begin
         want = exp_q.pop_front();
         got.we    = bus.WE;
         got.odd   = bus.ODD;
         got.addrw = bus.ADDRW;
         got.addrr = bus.ADDRR;
         got.rdy   = bus.RDY;
         got.busy  = bus.BUSY;
         checks++;
         if (got !== want) begin
            failures++;
            $display("FAIL outputs cycle=%0d got we=%0b odd=%0b addrw=%0d addrr=%0d rdy=%0b busy=%0b expected we=%0b odd=%0b addrw=%0d addrr=%0d rdy=%0b busy=%0b",
                     cyc, got.we, got.odd, got.addrw, got.addrr, got.rdy, got.busy,
                     want.we, want.odd, want.addrw, want.addrr, want.rdy, want.busy);
         end
      end
   end

   // ------------------------------------------------------------------------
   // Stimulus
   // ------------------------------------------------------------------------
   initial begin
      rst       = 1'b1;
      bus.ED    = 1'b0;
      bus.START = 1'b0;
      @(posedge clk);
      model_edge(1'b1, 1'b0, 1'b0);

      // Reset state, with ED/START ignored under reset.
      step(1, 1, 0);
      step(1, 1, 1);
      step(0, 1, 0);                 // idle: nothing happens without START

      // Continuous stream: fill, halves swap, RDY per block.
      step(0, 1, 1);
      repeat (3 * N + 5) step(0, 1, 0);

      // ED toggling during RUN.
      repeat (2 * N + 7) begin
         step(0, 1, 0);
         step(0, 0, 0);
      end

      // Restart at write index 17 of block 2.
      step(0, 1, 1);
      repeat (N + 16) step(0, 1, 0);
      step(0, 1, 1);
      repeat (N + LAT + 6) step(0, 1, 0);

      // Reset at write index 10 of block 3, then idle until a new START.
      step(0, 1, 1);
      repeat (2 * N + 9) step(0, 1, 0);
      step(1, 1, 0);
      repeat (6) step(0, 1, 0);
      step(0, 0, 1);                 // START without ED is not a start
      repeat (3) step(0, 1, 0);

      // Random traffic.
      step(0, 1, 1);
      repeat (4000) begin
         step(($urandom % 600) == 0,
              ($urandom % 4) != 0,
              ($urandom % 250) == 0);
      end

      @(negedge clk);
      #1;
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL drain got %0d unchecked entries expected 0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/bufram_ctrl.md
BUFRAM_CTRL -- requirements
Module: bufram_ctrl

Interface
REQ-001 Parameter AW, default 5: block address width; block length N = 2^AW complex samples.
REQ-002 Parameter LAT, default 1: read latency of the attached 2x-block buffer RAM, in ED-qualified cycles from ADDRR to valid data.
REQ-003 CLK  in  1  the single clock; all logic on rising edge.
REQ-004 RST  in  1  reset, synchronous, active-high.
REQ-005 ED  in  1  clock enable; when low, every register holds.
REQ-006 START  in  1  one-cycle pulse qualified by ED; marks sample 0 of a new stream.
REQ-007 WE  out  1  buffer write enable.
REQ-008 ODD  out  1  buffer half select; the RAM writes half ~ODD and reads half ODD.
REQ-009 ADDRW  out  AW  write address within the current half.
REQ-010 ADDRR  out  AW  read address within the opposite half.
REQ-011 RDY  out  1  one-cycle pulse: buffer read data for sample 0 of a block is valid at RAM output.
REQ-012 BUSY  out  1  high in FILL or RUN.

Function
REQ-013 State machine states: IDLE, FILL (first block being written, no reads), RUN (block k written while block k-1 read).
REQ-014 WE, ODD, ADDRW, ADDRR and BUSY shall be registered; each refers to the input sample presented on the preceding ED-qualified cycle, so upstream data is registered once to align.
REQ-015 IDLE -> FILL on ED&START; write counter wcnt loads 0; on the next edge WE=1, ADDRW=0.
REQ-016 In FILL and RUN, each ED cycle without START increments wcnt modulo N; WE=1, ADDRW=wcnt.
REQ-017 At each wrap (wcnt from N-1 to 0), ODD shall toggle on the same edge on which ADDRW=0 is issued for the next block.
REQ-018 FILL -> RUN at the first wrap; the block just written is read during the following N ED cycles.
REQ-019 In RUN, read counter rcnt equals wcnt; ADDRR is derived from rcnt per REQ-027/028, updated on the same edge as ADDRW.
REQ-020 RDY shall pulse exactly LAT ED-qualified cycles after the edge that issues the rcnt=0 read address of each block in RUN, via an LAT-stage shift register advancing only on ED.
REQ-021 START while in FILL or RUN: restart -- wcnt=0, state FILL, ODD forced to 0, pending RDY pulses in the shift register cleared.
REQ-022 ED low: WE shall drop to 0 on the next edge; all counters, ODD, ADDRW, ADDRR, state and the RDY pipeline hold; RDY shall be 0 while ED is low.
REQ-023 The stream never ends on its own; block after block continues while ED pulses arrive, only RST or START alters the sequence.
REQ-024 In IDLE: WE=0, RDY=0, BUSY=0, ADDRW/ADDRR hold their last values.

Reset
REQ-025 When RST=1 at an edge: state IDLE, wcnt=0, ODD=0, WE=0, ADDRW=0, ADDRR=0, RDY=0, BUSY=0, RDY pipeline cleared; RST overrides ED and START.
REQ-026 RST asserted mid-block shall abandon the block; no RDY shall follow until a new START has filled a complete block.

Configuration
REQ-027 Macro BUFRAM_BITREV_READ_EN defined: ADDRR = rcnt with its AW bits reversed (bit i -> bit AW-1-i), giving bit-reversed FFT output order.
REQ-028 Macro undefined: ADDRR = rcnt (natural order); all other behaviour identical.

Verification
REQ-029 AW=5, LAT=1, ED=1, START at cycle 0 -> WE=1 from cycle 1, ADDRW 0..31 in cycles 1..32, ODD=0 then 1 at cycle 33, first RDY at cycle 34.
REQ-030 With BUFRAM_BITREV_READ_EN, same stimulus -> ADDRR sequence 0,16,8,24,4,... starting cycle 33; without macro -> 0,1,2,3,...
REQ-031 ED toggling 1,0,1,0 during RUN -> WE=0 and counters/ADDRW frozen in ED=0 cycles, no address skipped, RDY only in ED=1 cycles.
REQ-032 Second START at write index 17 of block 2 -> ADDRW restarts at 0, ODD=0, no RDY until 32 further ED cycles plus LAT.
REQ-033 RST at write index 10 of block 3 -> all outputs 0 next edge, state IDLE, WE stays 0 until a new START.
REQ-034 LAT=2, continuous ED -> RDY every 32 cycles, each pulse 2 cycles after ADDRR=0 is issued.
